// File: rtl/fp_alu_sequencer_pkg.sv
// Shared definitions for the FP ALU command sequencer: opcodes, result
// constants, response flag bit positions and sequencer state encodings.
package fp_alu_sequencer_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   localparam int unsigned FLG_OVF = 0;
   localparam int unsigned FLG_UNF = 1;
   localparam int unsigned FLG_INV = 2;
   localparam int unsigned FLG_TMO = 3;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_ISSUE,
      SEQ_MASK,
      SEQ_WAIT,
      SEQ_RESP
   } seq_state_e;

endpackage

// File: rtl/fp_alu_sequencer_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, wrap-around pointers,
// registered occupancy count. Pushes when full and pops when empty are ignored.
module fp_cmd_fifo
   import fp_alu_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 72
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             wr_data,
   input  logic                     pop,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Next pointer, count and storage contents.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fp_alu_sequencer.sv
// Issues buffered FP commands to the ALU one at a time, masks stale ALU
// status for one cycle after start, bounds each operation with a timeout
// and returns result/flags/tag on a valid/ready response port.
module fp_alu_sequencer
   import fp_alu_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TAG_W          = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [31:0]              cmd_a,
   input  logic [31:0]              cmd_b,
   input  logic [3:0]               cmd_op,
   input  logic [TAG_W-1:0]         cmd_tag,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_result,
   output logic [3:0]               rsp_flags,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              alu_operand_a,
   output logic [31:0]              alu_operand_b,
   output logic [3:0]               alu_operation,
   output logic                     alu_start,
   input  logic [31:0]              alu_result,
   input  logic                     alu_done,
   input  logic                     alu_overflow,
   input  logic                     alu_underflow,
   input  logic                     alu_invalid
);

   localparam int unsigned PW = 68 + TAG_W;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_e       state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [31:0]      opa_q, opa_d, opb_q, opb_d;
   logic [3:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   logic             fifo_full, fifo_empty, pop;
   logic [PW-1:0]    head;
   logic [31:0]      head_a, head_b;
   logic [3:0]       head_op;
   logic [TAG_W-1:0] head_tag;

   fp_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (PW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (cmd_valid),
      .wr_data ({cmd_a, cmd_b, cmd_op, cmd_tag}),
      .pop     (pop),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign {head_a, head_b, head_op, head_tag} = head;

   assign cmd_ready     = !fifo_full;
   assign alu_operand_a = opa_q;
   assign alu_operand_b = opb_q;
   assign alu_operation = op_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_flags     = rsp_flags_q;
   assign rsp_tag       = rsp_tag_q;

   // Sequencer next-state, timeout counter, operand/response capture, outputs.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      op_d         = op_q;
      tag_d        = tag_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_tag_d    = rsp_tag_q;
      pop          = 1'b0;
      alu_start    = 1'b0;
      rsp_valid    = 1'b0;
      unique case (state_q)
         SEQ_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               opa_d   = head_a;
               opb_d   = head_b;
               op_d    = head_op;
               tag_d   = head_tag;
               state_d = SEQ_ISSUE;
            end
         end
         SEQ_ISSUE: begin
            alu_start = 1'b1;
            state_d   = SEQ_MASK;
         end
         SEQ_MASK: begin
            timer_d = '0;
            state_d = SEQ_WAIT;
         end
         SEQ_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (alu_done) begin
               rsp_result_d          = alu_result;
               rsp_flags_d           = '0;
               rsp_flags_d[FLG_OVF]  = alu_overflow;
               rsp_flags_d[FLG_UNF]  = alu_underflow;
               // The ALU only refreshes invalid on divide; otherwise it is stale.
               rsp_flags_d[FLG_INV]  = alu_invalid && (op_q == OP_DIV);
               rsp_tag_d             = tag_q;
               state_d               = SEQ_RESP;
            end else if (timer_d == TW'(TIMEOUT_CYCLES)) begin
               rsp_result_d          = FP_QNAN;
               rsp_flags_d           = '0;
               rsp_flags_d[FLG_TMO]  = 1'b1;
               rsp_flags_d[FLG_INV]  = 1'b1;
               rsp_tag_d             = tag_q;
               state_d               = SEQ_RESP;
            end
         end
         SEQ_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = SEQ_IDLE;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // Sequencer state and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SEQ_IDLE;
         timer_q      <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_tag_q    <= rsp_tag_d;
      end
   end

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Directed bench for fp_alu_sequencer with a behavioural ALU stub.
module tb_fp_alu_sequencer;
   import fp_alu_sequencer_pkg::*;

   logic        clk, reset;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_a, cmd_b;
   logic [3:0]  cmd_op, cmd_tag;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags, rsp_tag;
   logic [2:0]  fifo_count;
   logic [31:0] alu_operand_a, alu_operand_b;
   logic [3:0]  alu_operation;
   logic        alu_start;
   logic [31:0] alu_result;
   logic        alu_done, alu_overflow, alu_underflow, alu_invalid;

   int total, bad, cyc;
   int stub_mode;   // 0: done 4 cycles after start, 1: never done, 2: done stuck high
   int stub_cnt;

   fp_alu_sequencer #(
      .DEPTH          (4),
      .TIMEOUT_CYCLES (64),
      .TAG_W          (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_a         (cmd_a),
      .cmd_b         (cmd_b),
      .cmd_op        (cmd_op),
      .cmd_tag       (cmd_tag),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_flags     (rsp_flags),
      .rsp_tag       (rsp_tag),
      .fifo_count    (fifo_count),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_operation (alu_operation),
      .alu_start     (alu_start),
      .alu_result    (alu_result),
      .alu_done      (alu_done),
      .alu_overflow  (alu_overflow),
      .alu_underflow (alu_underflow),
      .alu_invalid   (alu_invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hand-computed ALU answers for the directed vectors; anything else gives a^b.
   function automatic logic [31:0] stub_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      if (op == OP_ADD && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
      if (op == OP_MUL && a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
      if (op == OP_DIV && a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
      return a ^ b;
   endfunction

   // ALU stub: registered status, invalid refreshed only on divide.
   always @(posedge clk) begin
      if (stub_mode == 2) begin
         alu_done   <= 1'b1;
         alu_result <= 32'h1234_5678;
      end else if (alu_start) begin
         alu_done <= 1'b0;
         stub_cnt <= (stub_mode == 0) ? 3 : 0;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            alu_done      <= 1'b1;
            alu_result    <= stub_calc(alu_operand_a, alu_operand_b, alu_operation);
            alu_overflow  <= 1'b0;
            alu_underflow <= 1'b0;
            if (alu_operation == OP_DIV) alu_invalid <= (alu_operand_b[30:0] == '0);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [3:0] tag, output int acc, output bit ok);
      int n = 0;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      ok  = cmd_ready;
      acc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output int sc, output bit ok);
      int n = 0;
      while (!alu_start && n < 200) begin @(negedge clk); n++; end
      ok = alu_start;
      sc = cyc;
   endtask

   task automatic wait_rsp(output logic [31:0] r, output logic [3:0] f, output logic [3:0] t,
                           output int vc, output bit ok);
      int n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
      ok = rsp_valid; r = rsp_result; f = rsp_flags; t = rsp_tag; vc = cyc;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total += 10;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      if (rsp_result !== 32'h0) begin bad++; $display("FAIL rst_rsp_result got=%h exp=0", rsp_result); end
      if (rsp_flags !== 4'h0) begin bad++; $display("FAIL rst_rsp_flags got=%b exp=0", rsp_flags); end
      if (rsp_tag !== 4'h0) begin bad++; $display("FAIL rst_rsp_tag got=%h exp=0", rsp_tag); end
      if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
      if (alu_operand_a !== 32'h0) begin bad++; $display("FAIL rst_opa got=%h exp=0", alu_operand_a); end
      if (alu_operand_b !== 32'h0) begin bad++; $display("FAIL rst_opb got=%h exp=0", alu_operand_b); end
      if (alu_operation !== 4'h0) begin bad++; $display("FAIL rst_op got=%h exp=0", alu_operation); end
      if (alu_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", alu_start); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      int acc, sc, vc; bit ok1, ok2, ok3;
      logic [31:0] r; logic [3:0] f, t;
      send(32'h3FC00000, 32'h40100000, OP_ADD, 4'd3, acc, ok1);
      wait_start(sc, ok2);
      total++;
      if (!ok2 || sc != acc + 2) begin bad++; $display("FAIL add_start_cycle got=%0d exp=%0d", sc - acc, 2); end
      wait_rsp(r, f, t, vc, ok3);
      total += 6;
      if (!(ok1 && ok3)) begin bad++; $display("FAIL add_handshake got=%b%b exp=11", ok1, ok3); end
      if (vc != acc + 7) begin bad++; $display("FAIL add_rsp_cycle got=%0d exp=%0d", vc - acc, 7); end
      if (r !== 32'h40700000) begin bad++; $display("FAIL add_result got=%h exp=40700000", r); end
      if (f !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b exp=0000", f); end
      if (t !== 4'd3) begin bad++; $display("FAIL add_tag got=%0d exp=3", t); end
      if (alu_operation !== OP_ADD || alu_operand_a !== 32'h3FC00000)
         begin bad++; $display("FAIL add_hold got=%h/%h exp=%h/3fc00000", alu_operation, alu_operand_a, OP_ADD); end
   endtask

   task automatic test_div_stale_invalid();
      int acc, vc; bit ok1, ok2;
      logic [31:0] r; logic [3:0] f, t;
      send(32'h3F800000, 32'h00000000, OP_DIV, 4'd5, acc, ok1);
      wait_rsp(r, f, t, vc, ok2);
      total += 3;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL div_handshake got=%b%b exp=11", ok1, ok2); end
      if (f !== 4'b0100) begin bad++; $display("FAIL div_flags got=%b exp=0100", f); end
      if (r !== 32'h7F800000) begin bad++; $display("FAIL div_result got=%h exp=7f800000", r); end
      send(32'h3FC00000, 32'h40000000, OP_MUL, 4'd6, acc, ok1);
      wait_rsp(r, f, t, vc, ok2);
      total += 4;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL mul_handshake got=%b%b exp=11", ok1, ok2); end
      if (f !== 4'b0000) begin bad++; $display("FAIL mul_stale_inv_flags got=%b exp=0000", f); end
      if (r !== 32'h40400000) begin bad++; $display("FAIL mul_result got=%h exp=40400000", r); end
      if (t !== 4'd6) begin bad++; $display("FAIL mul_tag got=%0d exp=6", t); end
   endtask

   task automatic test_back_to_back();
      int acc, sc, vc; bit ok, okall;
      logic [31:0] r; logic [3:0] f, t;
      okall = 1'b1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(32'h100 + i, 32'h0F0F0000, OP_SUB, 4'(i), acc, ok);
         okall &= ok;
      end
      total += 3;
      if (!okall) begin bad++; $display("FAIL bp_accept got=0 exp=1"); end
      if (fifo_count !== 3'd4) begin bad++; $display("FAIL bp_fifo_count got=%0d exp=4", fifo_count); end
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_cmd_ready got=%b exp=0", cmd_ready); end
      for (int i = 0; i < 5; i++) begin
         wait_rsp(r, f, t, vc, ok);
         total += 2;
         if (!ok || t !== 4'(i)) begin bad++; $display("FAIL bp_tag_order got=%0d exp=%0d", t, i); end
         if (r !== ((32'h100 + i) ^ 32'h0F0F0000))
            begin bad++; $display("FAIL bp_result got=%h exp=%h", r, (32'h100 + i) ^ 32'h0F0F0000); end
         if (i < 4) begin
            wait_start(sc, ok);
            total++;
            if (!ok || sc != vc + 2) begin bad++; $display("FAIL b2b_start got=%0d exp=%0d", sc - vc, 2); end
         end
      end
   endtask

   task automatic test_timeout();
      int acc, sc, vc; bit ok1, ok2, ok3;
      logic [31:0] r; logic [3:0] f, t;
      stub_mode = 1;
      send(32'h3F800000, 32'h3F800000, 4'hF, 4'd9, acc, ok1);
      wait_start(sc, ok2);
      wait_rsp(r, f, t, vc, ok3);
      total += 5;
      if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL tmo_handshake got=%b%b%b exp=111", ok1, ok2, ok3); end
      if (vc != sc + 66) begin bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", vc - sc, 66); end
      if (r !== 32'h7FC00000) begin bad++; $display("FAIL tmo_result got=%h exp=7fc00000", r); end
      if (f !== 4'b1100) begin bad++; $display("FAIL tmo_flags got=%b exp=1100", f); end
      if (t !== 4'd9) begin bad++; $display("FAIL tmo_tag got=%0d exp=9", t); end
   endtask

   task automatic test_stale_done();
      int acc, sc, vc; bit ok1, ok2, ok3;
      logic [31:0] r; logic [3:0] f, t;
      stub_mode = 2;
      repeat (2) @(negedge clk);
      send(32'h40000000, 32'h40000000, OP_ADD, 4'd12, acc, ok1);
      wait_start(sc, ok2);
      total++;
      if (!ok2 || sc != acc + 2) begin bad++; $display("FAIL stale_start_cycle got=%0d exp=%0d", sc - acc, 2); end
      wait_rsp(r, f, t, vc, ok3);
      total += 3;
      if (!(ok1 && ok3)) begin bad++; $display("FAIL stale_handshake got=%b%b exp=11", ok1, ok3); end
      if (vc != sc + 3) begin bad++; $display("FAIL stale_rsp_cycle got=%0d exp=%0d", vc - sc, 3); end
      if (t !== 4'd12 || r !== 32'h12345678)
         begin bad++; $display("FAIL stale_rsp got=%0d/%h exp=12/12345678", t, r); end
      stub_mode = 0;
   endtask

   task automatic test_reset_in_wait();
      int acc, viol; bit ok, okall;
      stub_mode = 1;
      rsp_ready = 1'b0;
      okall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(32'h200 + i, 32'h1, OP_ADD, 4'(10 + i), acc, ok);
         okall &= ok;
      end
      repeat (2) @(negedge clk);
      total += 2;
      if (!okall || fifo_count !== 3'd2) begin bad++; $display("FAIL rw_queued got=%0d exp=2", fifo_count); end
      if (alu_operand_a !== 32'h200) begin bad++; $display("FAIL rw_inflight got=%h exp=200", alu_operand_a); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total += 3;
      if (fifo_count !== 3'd0) begin bad++; $display("FAIL rw_fifo_count got=%0d exp=0", fifo_count); end
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_rsp_valid got=%b exp=0", rsp_valid); end
      if (alu_start !== 1'b0) begin bad++; $display("FAIL rw_alu_start got=%b exp=0", alu_start); end
      stub_mode = 0;
      rsp_ready = 1'b1;
      viol = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid || alu_start) viol++;
      end
      rsp_ready = 1'b0;
      total++;
      if (viol != 0) begin bad++; $display("FAIL rw_no_late_rsp got=%0d exp=0", viol); end
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      stub_mode = 0; stub_cnt = 0;
      alu_done = 1'b0; alu_result = '0;
      alu_overflow = 1'b0; alu_underflow = 1'b0; alu_invalid = 1'b0;
      reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
      @(negedge clk);
      test_reset();
      test_add();
      test_div_stale_invalid();
      test_back_to_back();
      test_timeout();
      test_stale_done();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
